// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the 16-entry hex glyph table and output polarity helpers.
package seg7_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  typedef logic [SEG_W-1:0] seg_vec_t;

  // Places an {a,b,c,d,e,f,g} pattern onto the segment bit positions, DP clear.
  function automatic seg_vec_t segs(input logic [6:0] abcdefg);
    seg_vec_t v;
    v        = '0;
    v[SEG_A] = abcdefg[6];
    v[SEG_B] = abcdefg[5];
    v[SEG_C] = abcdefg[4];
    v[SEG_D] = abcdefg[3];
    v[SEG_E] = abcdefg[2];
    v[SEG_F] = abcdefg[1];
    v[SEG_G] = abcdefg[0];
    return v;
  endfunction

  localparam seg_vec_t HEX_GLYPH [16] = '{
    segs(7'b1111110), segs(7'b0110000), segs(7'b1101101), segs(7'b1111001),
    segs(7'b0110011), segs(7'b1011011), segs(7'b1011111), segs(7'b1110000),
    segs(7'b1111111), segs(7'b1111011), segs(7'b1110111), segs(7'b0011111),
    segs(7'b0001101), segs(7'b0111101), segs(7'b1001111), segs(7'b1000111)
  };

  function automatic seg_vec_t seg_polarity(input seg_vec_t seg_on, input logic active_low);
    return active_low ? ~seg_on : seg_on;
  endfunction

  function automatic seg_vec_t seg_off(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble plus decimal point to active-high {A..G,DP} segment vector.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg         = HEX_GLYPH[nibble];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver: PWM brightness, dead time and frame-synchronous
// double buffering. Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned SLOT_CYCLES    = 16,
  parameter int unsigned DEAD_CYCLES    = 1,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1,
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  refresh_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] numbers,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [N_DIGITS-1:0]   digit_sel_n,
  output logic [SEG_W-1:0]      seg_n,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam int unsigned         SLOT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned         ON_MAX     = SLOT_CYCLES - DEAD_CYCLES;
  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]    DIGIT_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_RST =
    (ON_MAX >= (32'd1 << BRIGHT_W)) ? '1 : BRIGHT_W'(ON_MAX);

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]      digit_q, digit_d;
  logic [4*N_DIGITS-1:0] stage_num_q, stage_num_d, shadow_num_q, shadow_num_d;
  logic [N_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic [BRIGHT_W-1:0]   stage_br_q, stage_br_d, shadow_br_q, shadow_br_d;
  logic                  pending_q, pending_d;

  logic [N_DIGITS-1:0]   digit_sel_n_q, digit_sel_n_d;
  logic [SEG_W-1:0]      seg_n_q, seg_n_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary, frame_edge;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank, lit;
  logic [N_DIGITS-1:0]   dig_onehot;
  logic [SEG_W-1:0]      dec_seg;
  logic [31:0]           slot_ext, on_cycles;

  assign boundary   = (slot_q == SLOT_LAST) && (digit_q == DIGIT_LAST);
  // Disabled scan has no frames, so every cycle acts as a commit point.
  assign frame_edge = !enable || boundary;

  always_comb begin
    slot_d       = slot_q;
    digit_d      = digit_q;
    stage_num_d  = stage_num_q;
    stage_dp_d   = stage_dp_q;
    stage_br_d   = stage_br_q;
    shadow_num_d = shadow_num_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_br_d  = shadow_br_q;
    pending_d    = pending_q;

    if (!enable) begin
      slot_d  = '0;
      digit_d = '0;
    end else if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + IDX_W'(1);
    end else begin
      slot_d  = slot_q + SLOT_W'(1);
    end

    if (load) begin
      stage_num_d = numbers;
      stage_dp_d  = dp;
      stage_br_d  = brightness;
    end

    if (frame_edge) begin
      if (load) begin
        shadow_num_d = numbers;
        shadow_dp_d  = dp;
        shadow_br_d  = brightness;
      end else if (pending_q) begin
        shadow_num_d = stage_num_q;
        shadow_dp_d  = stage_dp_q;
        shadow_br_d  = stage_br_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] blank_mask;

  // Walk down from the top digit; blanking stops at the first nonzero or dotted digit.
  always_comb begin
    logic leading;
    leading    = 1'b1;
    blank_mask = '0;
    for (int unsigned i = N_DIGITS; i > 1; i--) begin
      if ((shadow_num_q[4*(i-1) +: 4] != 4'h0) || shadow_dp_q[i-1]) leading = 1'b0;
      blank_mask[i-1] = leading;
    end
  end
`endif

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    dig_onehot = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (digit_q == IDX_W'(i)) begin
        cur_nib       = shadow_num_q[4*i +: 4];
        cur_dp        = shadow_dp_q[i];
        dig_onehot[i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        cur_blank     = blank_mask[i];
`endif
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  always_comb begin
    slot_ext      = 32'(slot_q);
    on_cycles     = (32'(shadow_br_q) < ON_MAX) ? 32'(shadow_br_q) : ON_MAX;
    lit           = enable && (slot_ext >= DEAD_CYCLES) && (slot_ext < DEAD_CYCLES + on_cycles);
    digit_sel_n_d = (lit ? dig_onehot : '0) ^ {N_DIGITS{DIG_ACTIVE_LOW}};
    seg_n_d       = seg_polarity((lit && !cur_blank) ? dec_seg : '0, SEG_ACTIVE_LOW);
    digit_idx_d   = digit_q;
    frame_done_d  = enable && boundary;
  end

  always_ff @(posedge refresh_clk) begin
    if (!rst_n) begin
      slot_q        <= '0;
      digit_q       <= '0;
      stage_num_q   <= '0;
      stage_dp_q    <= '0;
      stage_br_q    <= '0;
      shadow_num_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_br_q   <= BRIGHT_RST;
      pending_q     <= 1'b0;
      digit_sel_n_q <= {N_DIGITS{DIG_ACTIVE_LOW}};
      seg_n_q       <= seg_off(SEG_ACTIVE_LOW);
      digit_idx_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      stage_num_q   <= stage_num_d;
      stage_dp_q    <= stage_dp_d;
      stage_br_q    <= stage_br_d;
      shadow_num_q  <= shadow_num_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_br_q   <= shadow_br_d;
      pending_q     <= pending_d;
      digit_sel_n_q <= digit_sel_n_d;
      seg_n_q       <= seg_n_d;
      digit_idx_q   <= digit_idx_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign digit_sel_n = digit_sel_n_q;
  assign seg_n       = seg_n_q;
  assign digit_idx   = digit_idx_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-position model predicts every output each cycle,
// and a few hand-computed pins anchor that model at known scan positions.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;

  localparam int N     = 8;
  localparam int SLOT  = 16;
  localparam int DEAD  = 1;
  localparam int FRAME = N * SLOT;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ_SEG = 8'hFF;
`else
  localparam logic [7:0] LZ_SEG = 8'h03;
`endif

  logic        refresh_clk = 1'b0;
  logic        rst_n, enable, load;
  logic [31:0] numbers;
  logic [7:0]  dp;
  logic [3:0]  brightness;
  logic [7:0]  digit_sel_n, seg_n;
  logic [2:0]  digit_idx;
  logic        frame_done;

  seg7_scan_ctrl #(
    .N_DIGITS       (8),
    .SLOT_CYCLES    (16),
    .DEAD_CYCLES    (1),
    .BRIGHT_W       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .refresh_clk (refresh_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .numbers     (numbers),
    .dp          (dp),
    .brightness  (brightness),
    .digit_sel_n (digit_sel_n),
    .seg_n       (seg_n),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  always #5 refresh_clk = ~refresh_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  // Model state: scan position within the frame plus displayed/staged contents.
  int          pos, md, ms, on_c, nib;
  bit          lit, pending, model_valid = 1'b0;
  logic [31:0] m_num, s_num;
  logic [7:0]  m_dp, s_dp;
  int          m_br, s_br;
  logic [7:0]  exp_sel, exp_seg;
  int          exp_idx;
  bit          exp_fd;

  int          pin_cyc = -1;
  string       pin_name;
  logic [7:0]  pin_sel, pin_seg;
  int          pin_idx;
  bit          pin_fd;

  function automatic string lit_segs(input int v);
    case (v)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
      4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
      8: return "abcdefg";  9: return "abcdfg"; 10: return "abcefg"; 11: return "cdefg";
      12: return "deg";    13: return "bcdeg";  14: return "adefg";  default: return "aefg";
    endcase
  endfunction

  // Active-high {a..g,dp}: segment 'a' is bit 7, dp is bit 0.
  function automatic logic [7:0] glyph(input int v, input logic p);
    string s;
    logic [7:0] r;
    int k;
    s = lit_segs(v);
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      r[7-k] = 1'b1;
    end
    r[0] = p;
    return r;
  endfunction

  function automatic bit blanked(input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < N; j++)
      if (((m_num >> (4*j)) & 32'hF) != 0 || m_dp[j]) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  initial forever begin
    @(posedge refresh_clk);
    if (!rst_n) begin
      exp_sel = 8'hFF; exp_seg = 8'hFF; exp_idx = 0; exp_fd = 1'b0;
      pos = 0; m_num = '0; m_dp = '0; m_br = SLOT - DEAD;
      s_num = '0; s_dp = '0; s_br = 0; pending = 1'b0;
    end else begin
      md   = pos / SLOT;
      ms   = pos % SLOT;
      on_c = (m_br < SLOT - DEAD) ? m_br : SLOT - DEAD;
      lit  = enable && (ms >= DEAD) && (ms < DEAD + on_c);
      nib  = int'((m_num >> (4*md)) & 32'hF);
      exp_sel = lit ? ~(8'd1 << md) : 8'hFF;
      exp_seg = (lit && !blanked(md)) ? ~glyph(nib, m_dp[md]) : 8'hFF;
      exp_idx = md;
      exp_fd  = enable && (pos == FRAME - 1);
      if (!enable || pos == FRAME - 1) begin
        if (load) begin
          m_num = numbers; m_dp = dp; m_br = int'(brightness);
        end else if (pending) begin
          m_num = s_num; m_dp = s_dp; m_br = s_br;
        end
        pending = 1'b0;
      end else if (load) begin
        s_num = numbers; s_dp = dp; s_br = int'(brightness); pending = 1'b1;
      end
      pos = enable ? (pos + 1) % FRAME : 0;
    end
    model_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge refresh_clk);
    if (model_valid) begin
      chk("digit_sel_n", 32'(digit_sel_n), 32'(exp_sel));
      chk("seg_n",       32'(seg_n),       32'(exp_seg));
      chk("digit_idx",   32'(digit_idx),   32'(exp_idx));
      chk("frame_done",  32'(frame_done),  32'(exp_fd));
      if (ncyc == pin_cyc) begin
        chk({pin_name, ".sel"},  32'(digit_sel_n), 32'(pin_sel));
        chk({pin_name, ".seg"},  32'(seg_n),       32'(pin_seg));
        chk({pin_name, ".idx"},  32'(digit_idx),   32'(pin_idx));
        chk({pin_name, ".done"}, 32'(frame_done),  32'(pin_fd));
      end
    end
    ncyc++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refresh_clk);
    #1;
  endtask

  task automatic pin_next(input string nm, input logic [7:0] s, input logic [7:0] g,
                          input int i, input bit f);
    pin_name = nm; pin_sel = s; pin_seg = g; pin_idx = i; pin_fd = f;
    pin_cyc  = ncyc;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    numbers = '0; dp = '0; brightness = '0;
    cyc(2);
    pin_next("reset", 8'hFF, 8'hFF, 0, 1'b0);

    rst_n = 1'b1;
    numbers = 32'h0123_4567; brightness = 4'd15; load = 1'b1;
    cyc(1);
    load = 1'b0; enable = 1'b1;
    pin_next("d0_dead",  8'hFF, 8'hFF, 0, 1'b0);
    pin_next("d0_lit",   8'hFE, 8'h1F, 0, 1'b0);
    cyc(47);
    pin_next("d3_glyph4", 8'hF7, 8'h99, 3, 1'b0);
    cyc(77);
    pin_next("d7_last",  8'h7F, LZ_SEG, 7, 1'b1);

    brightness = 4'd4; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(131);
    pin_next("br4_on",   8'hFE, 8'h1F, 0, 1'b0);
    pin_next("br4_off",  8'hFF, 8'hFF, 0, 1'b0);

    cyc(38);
    numbers = 32'hFFFF_FFFF; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(4);
    pin_next("old_glyph", 8'hF7, 8'h99, 3, 1'b0);
    cyc(127);
    pin_next("new_glyph", 8'hF7, 8'h71, 3, 1'b0);

    brightness = 4'd0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(78);
    pin_next("br0_dark", 8'hFF, 8'hFF, 0, 1'b0);

    enable = 1'b0; numbers = 32'h0000_0050; brightness = 4'd15; load = 1'b1;
    cyc(1);
    load = 1'b0; enable = 1'b1;
    cyc(1);
    pin_next("lz_d0", 8'hFE, 8'h03, 0, 1'b0);
    cyc(15);
    pin_next("lz_d1", 8'hFD, 8'h49, 1, 1'b0);
    cyc(15);
    pin_next("lz_d2", 8'hFB, LZ_SEG, 2, 1'b0);
    cyc(79);
    pin_next("lz_d7", 8'h7F, LZ_SEG, 7, 1'b0);

    cyc(99);
    rst_n = 1'b0;
    pin_next("mid_reset", 8'hFF, 8'hFF, 0, 1'b0);
    rst_n = 1'b1;
    cyc(1);
    pin_next("post_reset", 8'hFE, 8'h03, 0, 1'b0);

    cyc(20);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(127);
    numbers = 32'h89AB_CDEF; dp = 8'h01; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    pin_next("bnd_load", 8'hFE, 8'h70, 0, 1'b0);

    cyc(260);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
